// File: rtl/loader_pkg.sv
// Shared constants for the serial instruction-memory boot loader.
package loader_pkg;

  localparam logic [7:0] LOADER_HEADER = 8'hA5;
  localparam int         LEN_WIDTH     = 16;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LEN_HI = 3'd1;
  localparam logic [2:0] ST_LEN_LO = 3'd2;
  localparam logic [2:0] ST_DATA   = 3'd3;
  localparam logic [2:0] ST_CSUM   = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;
  localparam logic [2:0] ST_ERROR  = 3'd6;

  // States between a header and its checksum, where the inter-byte timeout runs.
  function automatic logic in_packet(input logic [2:0] s);
    return (s == ST_LEN_HI) || (s == ST_LEN_LO) || (s == ST_DATA) || (s == ST_CSUM);
  endfunction

endpackage

// File: rtl/word_assembler.sv
// Packs four serial bytes, MSB first, into one 32-bit instruction word.
module word_assembler (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Clear,
  input  logic        Enable,
  input  logic        ByteValid,
  input  logic [7:0]  ByteData,
  output logic        WordValid,
  output logic [31:0] Word
);

  logic [23:0] shift_q;
  logic [1:0]  byte_count;
  logic        take;

  assign take = Enable && ByteValid;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      shift_q    <= '0;
      byte_count <= '0;
    end else if (Clear) begin
      shift_q    <= '0;
      byte_count <= '0;
    end else if (take) begin
      shift_q    <= {shift_q[15:0], ByteData};
      byte_count <= byte_count + 2'd1;
    end
  end

  // The fourth byte completes the word in the same cycle it arrives.
  assign WordValid = take && (byte_count == 2'd3);
  assign Word      = {shift_q, ByteData};

endmodule

// File: rtl/imem_loader.sv
// Serial boot loader: frames A5/LEN/payload/CSUM packets from the UART and
// writes consecutive instruction words into IM while holding the CPU in reset.
module imem_loader
  import loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter int          MAX_WORDS      = 1024,
  parameter int          TIMEOUT_CYCLES = 1_000_000
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        ByteValid,
  input  logic [7:0]  ByteData,
  output logic        IMWrite,
  output logic [31:0] IMAddress,
  output logic [31:0] IMWriteData,
  output logic        CpuHold,
  output logic        Done,
  output logic        Error
);

  localparam int                     TIMER_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TIMER_WIDTH-1:0] TIMER_LIMIT = TIMER_WIDTH'(TIMEOUT_CYCLES);
  localparam logic [31:0]            MAX_WORDS_U = 32'(MAX_WORDS);

  logic [2:0]             state;
  logic [2:0]             state_next;
  logic [7:0]             len_hi;
  logic [7:0]             csum;
  logic [LEN_WIDTH-1:0]   len_field;
  logic [LEN_WIDTH-1:0]   word_count;
  logic [LEN_WIDTH-1:0]   word_index;
  logic [TIMER_WIDTH-1:0] timer;
  logic                   header_seen;
  logic                   timed_out;
  logic                   data_phase;
  logic                   word_valid;
  logic [31:0]            word_data;

  assign header_seen = ByteValid && (ByteData == LOADER_HEADER) && !in_packet(state);
  assign len_field   = {len_hi, ByteData};
  assign data_phase  = (state == ST_DATA);
  // A strobe in the expiry cycle wins over the timeout.
  assign timed_out   = in_packet(state) && !ByteValid && (timer == TIMER_LIMIT);

  word_assembler u_word_assembler (
    .Clk       (Clk),
    .Rst       (Rst),
    .Clear     (header_seen),
    .Enable    (data_phase),
    .ByteValid (ByteValid),
    .ByteData  (ByteData),
    .WordValid (word_valid),
    .Word      (word_data)
  );

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (header_seen) state_next = ST_LEN_HI;
      end
      ST_LEN_HI: begin
        if (ByteValid) state_next = ST_LEN_LO;
      end
      ST_LEN_LO: begin
        if (ByteValid) begin
          if ({{(32-LEN_WIDTH){1'b0}}, len_field} > MAX_WORDS_U) state_next = ST_ERROR;
          else if (len_field == '0)                             state_next = ST_CSUM;
          else                                                  state_next = ST_DATA;
        end
      end
      ST_DATA: begin
        if (word_valid && (word_index == word_count - LEN_WIDTH'(1))) state_next = ST_CSUM;
      end
      ST_CSUM: begin
        if (ByteValid) state_next = (ByteData == csum) ? ST_DONE : ST_ERROR;
      end
      default: state_next = ST_IDLE;
    endcase
    if (timed_out) state_next = ST_ERROR;
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) state <= ST_IDLE;
    else      state <= state_next;
  end

  // Status flags are levels; a failed load deliberately keeps the CPU held.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      CpuHold <= 1'b0;
      Done    <= 1'b0;
      Error   <= 1'b0;
    end else if (header_seen) begin
      CpuHold <= 1'b1;
      Done    <= 1'b0;
      Error   <= 1'b0;
    end else if ((state_next == ST_DONE) && (state != ST_DONE)) begin
      CpuHold <= 1'b0;
      Done    <= 1'b1;
    end else if ((state_next == ST_ERROR) && (state != ST_ERROR)) begin
      Error   <= 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      len_hi      <= '0;
      word_count  <= '0;
      csum        <= '0;
      word_index  <= '0;
      IMWrite     <= 1'b0;
      IMAddress   <= BASE_ADDR;
      IMWriteData <= '0;
    end else begin
      IMWrite <= 1'b0;
      if (header_seen) begin
        csum <= '0;
      end else if (ByteValid && ((state == ST_LEN_HI) || (state == ST_LEN_LO) || data_phase)) begin
        csum <= csum ^ ByteData;
      end
      if ((state == ST_LEN_HI) && ByteValid) len_hi <= ByteData;
      if ((state == ST_LEN_LO) && ByteValid) word_count <= len_field;
      // Address and data hold between writes so IM sees stable values.
      if (header_seen) begin
        word_index <= '0;
      end else if (word_valid) begin
        IMWrite     <= 1'b1;
        IMAddress   <= BASE_ADDR + {{(30-LEN_WIDTH){1'b0}}, word_index, 2'b00};
        IMWriteData <= word_data;
        word_index  <= word_index + LEN_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst)                                           timer <= '0;
    else if (!in_packet(state) || ByteValid || timed_out) timer <= '0;
    else                                                timer <= timer + TIMER_WIDTH'(1);
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: packet-level reference model compared
// every cycle, plus hand-computed expectations after each directed packet.
module tb_imem_loader;

  localparam logic [31:0] BASE      = 32'h0000_0040;
  localparam int          MAXW      = 1024;
  localparam int          TIMEOUT   = 16;

  typedef logic [7:0] byte_q_t[$];

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic        ByteValid = 1'b0;
  logic [7:0]  ByteData = 8'h00;
  logic        IMWrite;
  logic [31:0] IMAddress;
  logic [31:0] IMWriteData;
  logic        CpuHold;
  logic        Done;
  logic        Error;

  int checks = 0;
  int errors = 0;
  int dut_writes = 0;

  // Reference model state: position within the current packet.
  logic        m_active = 1'b0;
  int          m_pos = 0;
  int          m_len = 0;
  int          m_idle = 0;
  logic [7:0]  m_xor = 8'h00;
  logic [31:0] m_word = 32'h0;
  logic        exp_hold = 1'b0;
  logic        exp_done = 1'b0;
  logic        exp_error = 1'b0;
  logic        exp_write = 1'b0;
  logic [31:0] exp_addr = BASE;
  logic [31:0] exp_data = 32'h0;

  imem_loader #(
    .BASE_ADDR      (BASE),
    .MAX_WORDS      (MAXW),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .Clk         (Clk),
    .Rst         (Rst),
    .ByteValid   (ByteValid),
    .ByteData    (ByteData),
    .IMWrite     (IMWrite),
    .IMAddress   (IMAddress),
    .IMWriteData (IMWriteData),
    .CpuHold     (CpuHold),
    .Done        (Done),
    .Error       (Error)
  );

  always #5 Clk = ~Clk;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic model_reset();
    m_active  = 1'b0;
    m_pos     = 0;
    m_len     = 0;
    m_idle    = 0;
    m_xor     = 8'h00;
    m_word    = 32'h0;
    exp_hold  = 1'b0;
    exp_done  = 1'b0;
    exp_error = 1'b0;
    exp_write = 1'b0;
    exp_addr  = BASE;
    exp_data  = 32'h0;
  endtask

  task automatic model_fail();
    m_active  = 1'b0;
    exp_error = 1'b1;
  endtask

  task automatic model_byte(input logic [7:0] b);
    if (!m_active) begin
      if (b == 8'hA5) begin
        m_active  = 1'b1;
        m_pos     = 0;
        m_xor     = 8'h00;
        exp_hold  = 1'b1;
        exp_done  = 1'b0;
        exp_error = 1'b0;
      end
    end else begin
      m_pos++;
      if (m_pos == 1) begin
        m_xor = m_xor ^ b;
        m_len = int'(b) * 256;
      end else if (m_pos == 2) begin
        m_xor = m_xor ^ b;
        m_len = m_len + int'(b);
        if (m_len > MAXW) model_fail();
      end else if (m_pos <= 2 + 4 * m_len) begin
        m_xor  = m_xor ^ b;
        m_word = {m_word[23:0], b};
        if ((m_pos - 2) % 4 == 0) begin
          exp_write = 1'b1;
          exp_addr  = BASE + 32'(4 * ((m_pos - 2) / 4 - 1));
          exp_data  = m_word;
        end
      end else begin
        if (b == m_xor) begin
          m_active = 1'b0;
          exp_done = 1'b1;
          exp_hold = 1'b0;
        end else begin
          model_fail();
        end
      end
    end
  endtask

  always @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      model_reset();
    end else begin
      exp_write = 1'b0;
      if (ByteValid) begin
        model_byte(ByteData);
        m_idle = 0;
      end else if (m_active) begin
        if (m_idle == TIMEOUT) model_fail();
        else m_idle++;
      end
    end
  end

  always @(negedge Clk) begin
    check_output("IMWrite", 32'(IMWrite), 32'(exp_write));
    check_output("IMAddress", IMAddress, exp_addr);
    check_output("IMWriteData", IMWriteData, exp_data);
    check_output("CpuHold", 32'(CpuHold), 32'(exp_hold));
    check_output("Done", 32'(Done), 32'(exp_done));
    check_output("Error", 32'(Error), 32'(exp_error));
    if (IMWrite === 1'b1) dut_writes++;
  end

  task automatic apply_stimulus(input logic [7:0] b);
    @(negedge Clk);
    ByteValid = 1'b1;
    ByteData  = b;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge Clk);
      ByteValid = 1'b0;
    end
  endtask

  task automatic send_packet(input byte_q_t pkt);
    foreach (pkt[i]) apply_stimulus(pkt[i]);
    idle(3);
  endtask

  task automatic check_flags(input string tag, input logic hold, input logic done, input logic err);
    #1;
    check_output({tag, "_CpuHold"}, 32'(CpuHold), 32'(hold));
    check_output({tag, "_Done"}, 32'(Done), 32'(done));
    check_output({tag, "_Error"}, 32'(Error), 32'(err));
  endtask

  initial begin
    byte_q_t pkt_good;
    byte_q_t pkt_bad;
    int w0;

    pkt_good = '{8'hA5, 8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05,
                 8'h01, 8'h09, 8'h50, 8'h20, 8'h57};
    pkt_bad  = '{8'hA5, 8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05,
                 8'h01, 8'h09, 8'h50, 8'h20, 8'h2C};

    #1 Rst = 1'b0;
    #2;
    check_output("rst_IMAddress", IMAddress, 32'h0000_0040);
    check_output("rst_IMWriteData", IMWriteData, 32'h0);
    check_output("rst_IMWrite", 32'(IMWrite), 32'h0);
    check_flags("rst", 1'b0, 1'b0, 1'b0);
    #9 Rst = 1'b1;

    // Garbage before any header is ignored.
    apply_stimulus(8'h3C);
    apply_stimulus(8'hFF);
    idle(3);
    check_flags("garbage", 1'b0, 1'b0, 1'b0);

    // Good two-word packet.
    w0 = dut_writes;
    send_packet(pkt_good);
    check_flags("good", 1'b0, 1'b1, 1'b0);
    check_output("good_writes", 32'(dut_writes - w0), 32'd2);
    check_output("good_last_addr", IMAddress, 32'h0000_0044);
    check_output("good_last_data", IMWriteData, 32'h0109_5020);

    // Bad checksum: writes still happen, CPU stays held.
    w0 = dut_writes;
    send_packet(pkt_bad);
    check_flags("badcsum", 1'b1, 1'b0, 1'b1);
    check_output("badcsum_writes", 32'(dut_writes - w0), 32'd2);

    // Length 1025 exceeds capacity, then a good packet recovers.
    w0 = dut_writes;
    send_packet('{8'hA5, 8'h04, 8'h01});
    check_flags("toolong", 1'b1, 1'b0, 1'b1);
    check_output("toolong_writes", 32'(dut_writes - w0), 32'd0);
    send_packet(pkt_good);
    check_flags("recover", 1'b0, 1'b1, 1'b0);

    // Empty packet after garbage.
    w0 = dut_writes;
    send_packet('{8'h3C, 8'hFF, 8'hA5, 8'h00, 8'h00, 8'h00});
    check_flags("empty", 1'b0, 1'b1, 1'b0);
    check_output("empty_writes", 32'(dut_writes - w0), 32'd0);

    // Byte arriving on the expiry cycle keeps the load alive; A5 in payload is data.
    apply_stimulus(8'hA5);
    apply_stimulus(8'h00);
    apply_stimulus(8'h01);
    apply_stimulus(8'hA5);
    apply_stimulus(8'h12);
    apply_stimulus(8'h34);
    idle(TIMEOUT);
    apply_stimulus(8'h56);
    apply_stimulus(8'hD4);
    idle(3);
    check_flags("lastcycle", 1'b0, 1'b1, 1'b0);
    check_output("lastcycle_data", IMWriteData, 32'hA512_3456);
    check_output("lastcycle_addr", IMAddress, 32'h0000_0040);

    // Silence: Error appears exactly TIMEOUT+1 cycles after the last strobe.
    apply_stimulus(8'hA5);
    apply_stimulus(8'h00);
    apply_stimulus(8'h01);
    apply_stimulus(8'h12);
    apply_stimulus(8'h34);
    idle(TIMEOUT + 1);
    check_flags("timeout_before", 1'b1, 1'b0, 1'b0);
    @(negedge Clk);
    check_flags("timeout_after", 1'b1, 1'b0, 1'b1);

    // Asynchronous reset mid-DATA, then a full reload from BASE.
    apply_stimulus(8'hA5);
    apply_stimulus(8'h00);
    apply_stimulus(8'h03);
    apply_stimulus(8'h11);
    apply_stimulus(8'h22);
    apply_stimulus(8'h33);
    apply_stimulus(8'h44);
    apply_stimulus(8'h55);
    idle(1);
    #2 Rst = 1'b0;
    #1;
    check_output("arst_IMAddress", IMAddress, 32'h0000_0040);
    check_output("arst_IMWriteData", IMWriteData, 32'h0);
    check_output("arst_IMWrite", 32'(IMWrite), 32'h0);
    check_flags("arst", 1'b0, 1'b0, 1'b0);
    @(negedge Clk);
    #2 Rst = 1'b1;
    w0 = dut_writes;
    send_packet(pkt_good);
    check_flags("reload", 1'b0, 1'b1, 1'b0);
    check_output("reload_writes", 32'(dut_writes - w0), 32'd2);
    check_output("reload_last_addr", IMAddress, 32'h0000_0044);

    idle(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
